// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through a programmed note list and drives f_dHz/tone_en.
// Note word: [3:0] semitone (12..15 = rest), [5:4] octave, [9:6] duration ticks minus one.
module melody_sequencer #(
  parameter  int unsigned TICK_CYCLES = 12_500_000,
  parameter  int unsigned GAP_CYCLES  = 1_000_000,
  parameter  int unsigned DEPTH       = 16,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [9:0]    wr_data,
  input  logic [AW:0]   seq_len,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  output logic [31:0]   f_dHz,
  output logic          tone_en,
  output logic          busy,
  output logic [AW-1:0] step,
  output logic          done
);

  // state  | meaning
  // S_IDLE | waiting for start; sequence RAM writable
  // S_PLAY | note (or rest) sounding for (dur+1) ticks
  // S_GAP  | silent gap after a step, f_dHz held
  // S_DONE | one-cycle done pulse, then back to idle
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] step_q, step_d;
  logic [31:0]   timer_q, timer_d;
  logic [31:0]   f_q, f_d;
  logic          tone_q, tone_d;
  logic          done_q, done_d;
  logic          busy_q;

  logic [9:0]    ram [DEPTH];
  logic [AW-1:0] rd_addr;
  logic [9:0]    rd_word;
  logic [31:0]   rd_freq;
  logic [31:0]   note_cycles;
  logic          rd_rest;
  logic [AW:0]   step_p1;
  logic          last;
  logic          load;
  logic          advance;

  function automatic logic [31:0] note_freq(input logic [9:0] w);
    logic [31:0] base;
    case (w[3:0])
      4'd0:    base = 32'd2616;
      4'd1:    base = 32'd2772;
      4'd2:    base = 32'd2937;
      4'd3:    base = 32'd3111;
      4'd4:    base = 32'd3296;
      4'd5:    base = 32'd3492;
      4'd6:    base = 32'd3700;
      4'd7:    base = 32'd3920;
      4'd8:    base = 32'd4153;
      4'd9:    base = 32'd4400;
      4'd10:   base = 32'd4662;
      4'd11:   base = 32'd4939;
      default: base = 32'd0;
    endcase
    case (w[5:4])
      2'd0:    return base >> 1;
      2'd1:    return base;
      2'd2:    return base << 1;
      default: return base << 2;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en && state_q == S_IDLE) ram[wr_addr] <= wr_data;
  end

  assign step_p1 = {1'b0, step_q} + (AW+1)'(1);
  assign last    = step_p1 >= seq_len;
  assign rd_addr = (state_q == S_IDLE || last) ? '0 : step_q + AW'(1);

  // A write in the same cycle as start must be seen by step 0.
  assign rd_word     = (wr_en && state_q == S_IDLE && wr_addr == rd_addr) ? wr_data : ram[rd_addr];
  assign rd_rest     = rd_word[3:0] >= 4'd12;
  assign rd_freq     = note_freq(rd_word);
  assign note_cycles = (32'(rd_word[9:6]) + 32'd1) * TICK_CYCLES - 32'd1;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    timer_d = timer_q;
    f_d     = f_q;
    tone_d  = tone_q;
    done_d  = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    if (timer_q != '0) timer_d = timer_q - 32'd1;

    case (state_q)
      S_IDLE: if (start && !stop && seq_len != '0) load = 1'b1;
      S_PLAY: begin
        if (timer_q == '0) begin
          if (GAP_CYCLES != 0) begin
            state_d = S_GAP;
            timer_d = GAP_CYCLES - 1;
            tone_d  = 1'b0;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_GAP:  if (timer_q == '0) advance = 1'b1;
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (!last || loop) begin
        load = 1'b1;
      end else begin
        state_d = S_DONE;
        done_d  = 1'b1;
        tone_d  = 1'b0;
        f_d     = '0;
      end
    end

    if (load) begin
      state_d = S_PLAY;
      step_d  = rd_addr;
      timer_d = note_cycles;
      f_d     = rd_freq;
      tone_d  = !rd_rest;
    end

    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      step_d  = '0;
      timer_d = '0;
      f_d     = '0;
      tone_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      timer_q <= '0;
      f_q     <= '0;
      tone_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      timer_q <= timer_d;
      f_q     <= f_d;
      tone_q  <= tone_d;
      done_q  <= done_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign f_dHz   = f_q;
  assign tone_en = tone_q;
  assign busy    = busy_q;
  assign step    = step_q;
  assign done    = done_q;

endmodule
